// File: rtl/segasys1_sound_cmd.sv
// Sound-command bridge: main-CPU command latch, NMI pulse per command and the
// periodic maskable IRQ that paces the sound Z80 driver.
module segasys1_sound_cmd #(
   parameter int IRQ_DIV  = 16667,
   parameter int NMI_LEN  = 8,
   parameter int INT_HOLD = 64
) (
   input  logic        CLK48M,
   input  logic        RESET,
   input  logic        SCPU_CLKEN,
   input  logic        SNDRQ,
   input  logic [7:0]  SNDNO,
   input  logic [15:0] SCPU_AD,
   input  logic        SCPU_MREQ,
   input  logic        SCPU_IORQ,
   input  logic        SCPU_RD,
   input  logic        SCPU_M1,
   output logic        LATCH_CS,
   output logic [7:0]  LATCH_DO,
   output logic        SCPU_NMI,
   output logic        SCPU_INT,
   output logic        PENDING,
   output logic        OVERRUN
);

   localparam int NMI_W  = $clog2(NMI_LEN + 1);
   localparam int DIV_W  = $clog2(IRQ_DIV + 1);
   localparam int HOLD_W = $clog2(INT_HOLD + 1);

   typedef enum logic {NMI_IDLE, NMI_PULSE} nmi_state_t;
   typedef enum logic {IRQ_IDLE, IRQ_ASSERTED} irq_state_t;

   logic [7:0]  latch_q;
   logic        pending_q, overrun_q;
   logic        read_clr;
   logic        unused_ad;

   nmi_state_t  nmi_state, nmi_next;
   logic [NMI_W-1:0] nmi_cnt, nmi_cnt_next;

   irq_state_t  irq_state, irq_next;
   logic [DIV_W-1:0]  div_cnt;
   logic [HOLD_W-1:0] hold_cnt, hold_next;
   logic        div_wrap, irq_ack;

   assign LATCH_CS  = SCPU_MREQ & SCPU_RD & (SCPU_AD[15:12] == 4'hE);
   assign read_clr  = LATCH_CS & SCPU_CLKEN;
   assign unused_ad = ^SCPU_AD[11:0];

   // A write on the same edge as a read wins and is not counted as an overrun.
   always_ff @(posedge CLK48M or posedge RESET) begin
      if (RESET) begin
         latch_q   <= 8'h00;
         pending_q <= 1'b0;
         overrun_q <= 1'b0;
      end else if (SNDRQ) begin
         latch_q   <= SNDNO;
         pending_q <= 1'b1;
         if (pending_q && !read_clr)
            overrun_q <= 1'b1;
      end else if (read_clr) begin
         pending_q <= 1'b0;
      end
   end

   always_ff @(posedge CLK48M or posedge RESET) begin
      if (RESET) begin
         nmi_state <= NMI_IDLE;
         nmi_cnt   <= '0;
      end else begin
         nmi_state <= nmi_next;
         nmi_cnt   <= nmi_cnt_next;
      end
   end

   always_comb begin
      nmi_next     = nmi_state;
      nmi_cnt_next = nmi_cnt;
      if (SNDRQ) begin
         nmi_next     = NMI_PULSE;
         nmi_cnt_next = NMI_W'(NMI_LEN);
      end else if (nmi_state == NMI_PULSE) begin
         if (nmi_cnt == '0)
            nmi_next = NMI_IDLE;
         else if (SCPU_CLKEN)
            nmi_cnt_next = nmi_cnt - NMI_W'(1);
      end
   end

   assign div_wrap = SCPU_CLKEN && (div_cnt == DIV_W'(IRQ_DIV - 1));
   assign irq_ack  = SCPU_M1 & SCPU_IORQ & SCPU_CLKEN;

   always_ff @(posedge CLK48M or posedge RESET) begin
      if (RESET)
         div_cnt <= '0;
      else if (SCPU_CLKEN)
         div_cnt <= div_wrap ? '0 : div_cnt + DIV_W'(1);
   end

   always_ff @(posedge CLK48M or posedge RESET) begin
      if (RESET) begin
         irq_state <= IRQ_IDLE;
         hold_cnt  <= '0;
      end else begin
         irq_state <= irq_next;
         hold_cnt  <= hold_next;
      end
   end

   // A new period always re-arms the request, even against a same-edge acknowledge.
   always_comb begin
      irq_next  = irq_state;
      hold_next = hold_cnt;
      if (div_wrap) begin
         irq_next  = IRQ_ASSERTED;
         hold_next = HOLD_W'(INT_HOLD);
      end else if (irq_state == IRQ_ASSERTED) begin
         if (irq_ack) begin
            irq_next  = IRQ_IDLE;
            hold_next = '0;
         end else if (SCPU_CLKEN) begin
            if (hold_cnt <= HOLD_W'(1)) begin
               irq_next  = IRQ_IDLE;
               hold_next = '0;
            end else begin
               hold_next = hold_cnt - HOLD_W'(1);
            end
         end
      end
   end

   assign LATCH_DO = latch_q;
   assign PENDING  = pending_q;
   assign OVERRUN  = overrun_q;
   assign SCPU_NMI = (nmi_state == NMI_PULSE);
   assign SCPU_INT = (irq_state == IRQ_ASSERTED);

endmodule

// File: tb/tb_segasys1_sound_cmd.sv
// Directed bench for segasys1_sound_cmd: latch vector table, then hand-written
// NMI, IRQ and mid-operation reset sequences.
module tb_segasys1_sound_cmd;

   logic        CLK48M, RESET, SCPU_CLKEN, SNDRQ;
   logic [7:0]  SNDNO;
   logic [15:0] SCPU_AD;
   logic        SCPU_MREQ, SCPU_IORQ, SCPU_RD, SCPU_M1;
   logic        LATCH_CS, SCPU_NMI, SCPU_INT, PENDING, OVERRUN;
   logic [7:0]  LATCH_DO;

   int n_checks = 0;
   int n_fail   = 0;
   int clken_div = 4;
   int phase     = 0;
   int en_edges  = 0;

   typedef struct {
      logic        wr;
      logic [7:0]  no;
      logic [15:0] ad;
      logic        mreq;
      logic        rd;
      logic        on_clken;
      logic        exp_cs;
      logic [7:0]  exp_do;
      logic        exp_pend;
      logic        exp_ovr;
   } vec_t;

   vec_t vecs[12];

   segasys1_sound_cmd dut (
      .CLK48M(CLK48M), .RESET(RESET), .SCPU_CLKEN(SCPU_CLKEN),
      .SNDRQ(SNDRQ), .SNDNO(SNDNO), .SCPU_AD(SCPU_AD),
      .SCPU_MREQ(SCPU_MREQ), .SCPU_IORQ(SCPU_IORQ), .SCPU_RD(SCPU_RD),
      .SCPU_M1(SCPU_M1), .LATCH_CS(LATCH_CS), .LATCH_DO(LATCH_DO),
      .SCPU_NMI(SCPU_NMI), .SCPU_INT(SCPU_INT), .PENDING(PENDING),
      .OVERRUN(OVERRUN)
   );

   initial CLK48M = 1'b0;
   always #5 CLK48M = ~CLK48M;

   task automatic check_output(input string name, input int act, input int exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Inputs change 1 time unit after each rising edge; en_edges counts enabled edges out of reset.
   task automatic tick();
      @(posedge CLK48M);
      if (SCPU_CLKEN && !RESET) en_edges++;
      #1;
      phase      = (phase + 1) % clken_div;
      SCPU_CLKEN = (phase == 0);
   endtask

   task automatic align(input logic want);
      for (int i = 0; i < 8 && SCPU_CLKEN !== want; i++) tick();
   endtask

   task automatic do_reset();
      RESET = 1'b1;
      tick();
      tick();
      RESET    = 1'b0;
      en_edges = 0;
   endtask

   task automatic apply_stimulus(input vec_t v, input int idx);
      align(v.on_clken);
      SNDRQ     = v.wr;
      SNDNO     = v.no;
      SCPU_AD   = v.ad;
      SCPU_MREQ = v.mreq;
      SCPU_RD   = v.rd;
      #1;
      check_output($sformatf("v%0d_cs", idx), int'(LATCH_CS), int'(v.exp_cs));
      tick();
      SNDRQ     = 1'b0;
      SCPU_MREQ = 1'b0;
      SCPU_RD   = 1'b0;
      SCPU_AD   = 16'h0000;
      check_output($sformatf("v%0d_do", idx), int'(LATCH_DO), int'(v.exp_do));
      check_output($sformatf("v%0d_pend", idx), int'(PENDING), int'(v.exp_pend));
      check_output($sformatf("v%0d_ovr", idx), int'(OVERRUN), int'(v.exp_ovr));
   endtask

   // Counts enables seen while NMI is high; optionally re-strobes after reload_after enables.
   task automatic run_nmi(input int reload_after, output int cnt);
      logic reloaded;
      cnt      = 0;
      reloaded = (reload_after < 0);
      for (int i = 0; i < 200; i++) begin
         tick();
         SNDRQ = 1'b0;
         if (!SCPU_NMI) break;
         if (SCPU_CLKEN) cnt++;
         if (!reloaded && cnt == reload_after && !SCPU_CLKEN) begin
            SNDRQ    = 1'b1;
            SNDNO    = 8'h22;
            reloaded = 1'b1;
         end
      end
   endtask

   task automatic wait_int(input logic want, input string name);
      logic ok;
      ok = 1'b0;
      for (int i = 0; i < 20000; i++) begin
         tick();
         if (SCPU_INT == want) begin
            ok = 1'b1;
            break;
         end
      end
      check_output(name, int'(ok), 1);
   endtask

   initial begin
      int cnt, r1, r2;

      vecs[0]  = '{1'b1, 8'hA3, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 8'hA3, 1'b1, 1'b0};
      vecs[1]  = '{1'b0, 8'h00, 16'hE000, 1'b1, 1'b1, 1'b1, 1'b1, 8'hA3, 1'b0, 1'b0};
      vecs[2]  = '{1'b1, 8'h11, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 8'h11, 1'b1, 1'b0};
      vecs[3]  = '{1'b1, 8'h22, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 8'h22, 1'b1, 1'b1};
      vecs[4]  = '{1'b0, 8'h00, 16'hE123, 1'b1, 1'b1, 1'b1, 1'b1, 8'h22, 1'b0, 1'b1};
      vecs[5]  = '{1'b1, 8'h5A, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 8'h5A, 1'b1, 1'b1};
      vecs[6]  = '{1'b0, 8'h00, 16'hD000, 1'b1, 1'b1, 1'b1, 1'b0, 8'h5A, 1'b1, 1'b1};
      vecs[7]  = '{1'b0, 8'h00, 16'hE000, 1'b1, 1'b0, 1'b1, 1'b0, 8'h5A, 1'b1, 1'b1};
      vecs[8]  = '{1'b0, 8'h00, 16'hEFFF, 1'b0, 1'b1, 1'b1, 1'b0, 8'h5A, 1'b1, 1'b1};
      vecs[9]  = '{1'b0, 8'h00, 16'hE000, 1'b1, 1'b1, 1'b0, 1'b1, 8'h5A, 1'b1, 1'b1};
      vecs[10] = '{1'b0, 8'h00, 16'hFFFF, 1'b1, 1'b1, 1'b1, 1'b0, 8'h5A, 1'b1, 1'b1};
      vecs[11] = '{1'b0, 8'h00, 16'hEFFF, 1'b1, 1'b1, 1'b1, 1'b1, 8'h5A, 1'b0, 1'b1};

      RESET = 1'b1; SCPU_CLKEN = 1'b0; SNDRQ = 1'b0; SNDNO = 8'h00;
      SCPU_AD = 16'h0000; SCPU_MREQ = 1'b0; SCPU_IORQ = 1'b0;
      SCPU_RD = 1'b0; SCPU_M1 = 1'b0;

      repeat (3) tick();
      SNDRQ = 1'b1; SNDNO = 8'h55;
      tick();
      SNDRQ = 1'b0;
      tick();
      check_output("rst_do", int'(LATCH_DO), 8'h00);
      check_output("rst_pend", int'(PENDING), 0);
      check_output("rst_ovr", int'(OVERRUN), 0);
      check_output("rst_nmi", int'(SCPU_NMI), 0);
      check_output("rst_int", int'(SCPU_INT), 0);
      RESET = 1'b0;

      for (int i = 0; i < 12; i++) apply_stimulus(vecs[i], i);

      do_reset();
      apply_stimulus('{1'b1, 8'h33, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 8'h33, 1'b1, 1'b0}, 12);
      apply_stimulus('{1'b1, 8'h7E, 16'hE000, 1'b1, 1'b1, 1'b1, 1'b1, 8'h7E, 1'b1, 1'b0}, 13);

      do_reset();
      align(1'b0);
      SNDRQ = 1'b1; SNDNO = 8'hA3;
      run_nmi(-1, cnt);
      check_output("nmi_len", cnt, 8);
      check_output("nmi_end", int'(SCPU_NMI), 0);

      do_reset();
      align(1'b0);
      SNDRQ = 1'b1; SNDNO = 8'h11;
      run_nmi(3, cnt);
      check_output("nmi_reload_len", cnt, 11);
      check_output("ovr_do", int'(LATCH_DO), 8'h22);
      check_output("ovr_flag", int'(OVERRUN), 1);

      clken_div  = 1;
      SCPU_CLKEN = 1'b1;
      do_reset();
      wait_int(1'b1, "irq1_timeout");
      check_output("irq_first", en_edges, 16667);
      r1 = en_edges;
      wait_int(1'b0, "hold_timeout");
      check_output("int_hold", en_edges - r1, 64);
      wait_int(1'b1, "irq2_timeout");
      check_output("irq_period", en_edges - r1, 16667);
      r2 = en_edges;

      repeat (5) tick();
      check_output("int_before_ack", int'(SCPU_INT), 1);
      check_output("ack_offset", en_edges - r2, 5);
      SCPU_M1 = 1'b1; SCPU_IORQ = 1'b1;
      tick();
      SCPU_M1 = 1'b0; SCPU_IORQ = 1'b0;
      check_output("int_ack", int'(SCPU_INT), 0);

      wait_int(1'b1, "irq3_timeout");
      SNDRQ = 1'b1; SNDNO = 8'h44;
      tick();
      SNDRQ = 1'b0;
      check_output("mid_nmi_hi", int'(SCPU_NMI), 1);
      check_output("mid_int_hi", int'(SCPU_INT), 1);
      RESET = 1'b1;
      #1;
      check_output("async_nmi", int'(SCPU_NMI), 0);
      check_output("async_int", int'(SCPU_INT), 0);
      check_output("async_do", int'(LATCH_DO), 8'h00);
      check_output("async_pend", int'(PENDING), 0);
      tick();
      tick();
      RESET    = 1'b0;
      en_edges = 0;
      wait_int(1'b1, "irq_post_rst_timeout");
      check_output("irq_post_rst", en_edges, 16667);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/segasys1_sound_cmd.md
Name: segasys1_sound_cmd

Overview:
- Sound-command bridge between the main CPU block (SNDRQ/SNDNO) and the sound Z80.
- Holds the command byte in a latch and raises an NMI pulse on the sound CPU for each new command.
- Generates the periodic maskable IRQ that paces the sound driver.
- Returns the latch byte on sound-CPU reads of the latch window.

Parameters:
- IRQ_DIV, 16667, sound-clock enables between IRQ assertions (4 MHz / 240 Hz).
- NMI_LEN, 8, sound-clock enables that SCPU_NMI stays asserted after a command.
- INT_HOLD, 64, maximum sound-clock enables SCPU_INT stays asserted without an acknowledge.

Ports:
- CLK48M  in  1  system clock.
- RESET  in  1  async, active-high reset.
- SCPU_CLKEN  in  1  one-CLK48M-cycle sound-CPU clock enable.
- SNDRQ  in  1  one-cycle command strobe from main CPU.
- SNDNO  in  8  command byte, valid while SNDRQ=1.
- SCPU_AD  in  16  sound CPU address.
- SCPU_MREQ  in  1  sound CPU memory request, active high.
- SCPU_IORQ  in  1  sound CPU IO request, active high.
- SCPU_RD  in  1  sound CPU read, active high.
- SCPU_M1  in  1  sound CPU M1, active high.
- LATCH_CS  out  1  latch selected, for the sound data selector.
- LATCH_DO  out  8  latch contents.
- SCPU_NMI  out  1  NMI request, active high.
- SCPU_INT  out  1  IRQ request, active high.
- PENDING  out  1  command written and not yet read.
- OVERRUN  out  1  sticky: a command arrived while PENDING=1.

Behaviour:
- Reset: RESET is asynchronous and active-high; the clock is CLK48M. On RESET, all registers are cleared:
  - LATCH_DO=0, PENDING=0, OVERRUN=0, SCPU_NMI=0, SCPU_INT=0.
  - NMI counter=0, IRQ divider=0, INT-hold counter=0.
  - Asserting RESET mid-pulse aborts the pulse immediately.
- Latch write: on a CLK48M edge with SNDRQ=1, LATCH_DO<=SNDNO, with no wait for SCPU_CLKEN.
  - PENDING<=1 on the same edge.
  - If PENDING was already 1, OVERRUN<=1. OVERRUN is cleared only by RESET.
- Latch read:
  - LATCH_CS = SCPU_MREQ & SCPU_RD & (SCPU_AD[15:12]==4'hE), combinational.
  - LATCH_DO is driven continuously.
  - Clearing PENDING: on the first CLK48M edge where LATCH_CS=1 and SCPU_CLKEN=1, PENDING<=0.
  - If SNDRQ is also 1 on that edge, the write wins: the new byte is latched, PENDING stays 1, and OVERRUN is not set.
- NMI generator, states IDLE and PULSE:
  - Any edge with SNDRQ=1 goes to PULSE: SCPU_NMI<=1, counter<=NMI_LEN.
  - In PULSE, the counter decrements on each SCPU_CLKEN.
  - When the counter reaches 0, go to IDLE: SCPU_NMI<=0 on the edge after the decrement to 0.
  - SNDRQ during PULSE reloads the counter and keeps SCPU_NMI high; no gap is produced, which matches the single-edge NMI semantics of the Z80.
- IRQ timer:
  - The divider increments on each SCPU_CLKEN and wraps from IRQ_DIV-1 to 0.
  - On the wrap, SCPU_INT<=1 and the hold counter<=INT_HOLD.
- IRQ states IDLE and ASSERTED. In ASSERTED, SCPU_INT drops on whichever comes first:
  - acknowledge: SCPU_M1 & SCPU_IORQ & SCPU_CLKEN;
  - timeout: the hold counter reaches 0, decrementing per SCPU_CLKEN.
- IRQ simultaneous events:
  - A wrap coinciding with an acknowledge: SCPU_INT stays 1 and the hold counter reloads.
  - A wrap while already ASSERTED: the hold counter reloads.
- Widths: every counter is $clog2(param+1) bits. No counter may roll over silently except the IRQ divider wrap described above.
- The divider free-runs and is independent of latch activity.

Test Plan:
- Reset: hold RESET high, pulse SNDRQ with SNDNO=0x55 -> LATCH_DO=0x00, PENDING=0, SCPU_NMI=0, SCPU_INT=0.
- Write/read: SNDRQ with SNDNO=0xA3 -> LATCH_DO=0xA3 next edge, PENDING=1, SCPU_NMI high for exactly 8 SCPU_CLKEN. Then sound read at 0xE000 -> LATCH_CS=1, data 0xA3, PENDING=0.
- Overrun: SNDRQ 0x11, then SNDRQ 0x22 before any read -> LATCH_DO=0x22, OVERRUN=1, NMI counter reloaded with no low gap. A following read clears PENDING; OVERRUN stays 1.
- Simultaneous: SNDRQ 0x7E on the same edge as a read with SCPU_CLKEN=1 -> LATCH_DO=0x7E, PENDING=1, OVERRUN=0.
- IRQ: run 2×IRQ_DIV enables with no acknowledge -> SCPU_INT high for exactly 64 enables per period, two assertions 16667 enables apart. Acknowledge (M1&IORQ) 5 enables after assertion -> SCPU_INT low on that edge.
- Reset mid-operation: assert RESET during an NMI pulse and an INT assertion -> both outputs low asynchronously. After release, the first IRQ comes exactly IRQ_DIV enables later.
